wdg_kick_sched: RTL and testbench
=================================

// Module: wdg_kick_sched
// PURPOSE
//  Supervises the external watchdog kick (WDI) for the control station. Toggles o_wdi at a fixed
//  rate only while every enabled software/firmware task has checked in within each supervision
//  window. If any task misses, the kicking stops, so the external watchdog IC resets the board.
//  Sits between the task heartbeat sources and the WDI pin. Replaces the free-running kick divider.
// PARAMETERS
//  HALF_PERIOD     25'd24900 : o_wdi toggles every HALF_PERIOD+1 clk; kick period is 2*(HALF_PERIOD+1) clk
//  N_TASK          4         : number of supervised tasks
//  WIN_TOGGLES     8         : supervision window length, in o_wdi toggles (>=1)
//  STARTUP_TOGGLES 64        : unconditional toggles after enable, before supervision starts (>=1)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       reset, synchronous, active-low
//  i_dog_en       in   1       1: enable supervision; 0: disable (o_wdi held 1)
//  i_task_mask    in   N_TASK  1 = task k is supervised; sampled only at window end
//  i_task_alive   in   N_TASK  1-clk heartbeat pulse per task (level is also accepted)
//  i_force_starve in   1       1-clk request to stop kicking immediately (test/diagnostic)
//  o_wdi          out  1       WDI pin to the external watchdog IC
//  o_state        out  2       0 IDLE, 1 STARTUP, 2 RUN, 3 STARVE
//  o_fault        out  1       sticky: supervision failed or starvation was forced
//  o_miss_tasks   out  N_TASK  tasks that missed the failing window (0 if forced)
//  o_kick_cnt     out  16      toggles since enable; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all counters, r_wdi, o_fault, o_miss_tasks and
//   o_kick_cnt are 0. o_wdi = 1 whenever the state is IDLE (o_wdi = (state==IDLE) | r_wdi).
//  Priority each clk: rst_n > i_dog_en==0 (any state -> IDLE next clk) > i_force_starve > normal.
//  Tick: cnt runs 0..HALF_PERIOD in STARTUP/RUN only. Terminal = cnt==HALF_PERIOD; then cnt->0.
//   r_wdi toggles on the registered edge at the terminal, so o_wdi changes 1 clk after cnt==HALF_PERIOD.
//  IDLE: if i_dog_en=1 -> STARTUP. On the same edge, clear cnt, the toggle count, seen, r_wdi,
//   o_fault, o_miss_tasks and o_kick_cnt. The first toggle is therefore HALF_PERIOD+1 clk after entry.
//  STARTUP: every terminal toggles. When the STARTUP_TOGGLES-th toggle occurs, go to RUN on the
//   same edge and clear the window count and seen. i_task_alive is ignored in this state.
//  RUN: every clk, seen <= seen | i_task_alive. Non-final terminals toggle normally.
//   At the WIN_TOGGLES-th terminal (window end):
//     hit = seen | i_task_alive (the same-clk pulse counts).
//     Pass, if (hit & i_task_mask) == i_task_mask: toggle, clear seen and the window count, stay in RUN.
//     Fail: no toggle; go to STARVE; o_miss_tasks <= i_task_mask & ~hit; o_fault <= 1.
//   i_task_mask==0 always passes.
//   i_force_starve=1 in RUN -> STARVE next clk, o_fault <= 1, o_miss_tasks <= 0. This overrides a
//   pass on the same clk. i_force_starve is ignored in other states.
//  STARVE: cnt frozen; r_wdi holds its last level; o_kick_cnt frozen. Exit only via i_dog_en=0 -> IDLE.
//   o_fault and o_miss_tasks stay until the next IDLE->STARTUP transition or reset.
//  o_kick_cnt: +1 on every actual toggle; holds at 16'hFFFF.
//  All outputs are registered except o_wdi (1 OR gate on registers). No combinational path from inputs.
//  A reset mid-operation returns to IDLE within 1 clk, with o_wdi=1. Mid-window progress is discarded.
// TESTING  (HALF_PERIOD=3, N_TASK=2, WIN_TOGGLES=4, STARTUP_TOGGLES=2 unless noted)
//  1 Reset, en=0 -> o_wdi=1, o_state=0, o_kick_cnt=0. Assert en -> o_state=1; o_wdi=0, then
//    first rise 5 clk after the en edge; o_state=2 after the 2nd toggle (clk 9).
//  2 mask=2'b11, pulse both alive once per window -> 4 consecutive windows pass; o_wdi square wave
//    with period 8 clk; o_fault=0; o_kick_cnt=18.
//  3 mask=2'b11, only task0 pulses -> at window end no toggle, o_state=3, o_miss_tasks=2'b10,
//    o_fault=1, o_wdi frozen for 100 clk.
//  4 Task1 pulse on exactly the window-end clk -> pass. Task1 pulse 1 clk after window end
//    -> counts for the next window only.
//  5 i_force_starve and a passing window end on the same clk -> STARVE, o_miss_tasks=0, no toggle.
//    Then en=0 -> IDLE, o_wdi=1; en=1 -> o_fault cleared.
//  6 rst_n=0 for 1 clk mid-RUN -> IDLE next clk, all outputs at reset values. o_kick_cnt
//    saturation: force the count to 16'hFFFE -> reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/wdg_kick_sched.sv
// rtl/wdg_kick_sched.sv - task-supervised external watchdog kick scheduler
//
// Purpose: toggles the WDI pin of an external watchdog IC at a fixed rate, but
// only while every supervised task keeps checking in once per supervision
// window. A missed window (or a forced starve request) stops the kicking so the
// watchdog IC resets the board.
//
// Ports:
//   clk            system clock
//   rst_n          synchronous active-low reset
//   i_dog_en       1: supervise and kick, 0: idle (o_wdi held high)
//   i_task_mask    supervised-task mask, sampled at window end
//   i_task_alive   per-task heartbeat pulses (levels also accepted)
//   i_force_starve request to stop kicking immediately (honoured in RUN only)
//   o_wdi          WDI pin
//   o_state        0 IDLE, 1 STARTUP, 2 RUN, 3 STARVE
//   o_fault        sticky supervision failure / forced starvation flag
//   o_miss_tasks   tasks that missed the failing window
//   o_kick_cnt     saturating count of toggles since enable

module wdg_kick_sched #(
  parameter logic [24:0] HALF_PERIOD     = 25'd24900,
  parameter int          N_TASK          = 4,
  parameter int          WIN_TOGGLES     = 8,
  parameter int          STARTUP_TOGGLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_dog_en,
  input  logic [N_TASK-1:0] i_task_mask,
  input  logic [N_TASK-1:0] i_task_alive,
  input  logic              i_force_starve,
  output logic              o_wdi,
  output logic [1:0]        o_state,
  output logic              o_fault,
  output logic [N_TASK-1:0] o_miss_tasks,
  output logic [15:0]       o_kick_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STARTUP = 2'd1,
    RUN     = 2'd2,
    STARVE  = 2'd3
  } state_t;

  // Toggle counter compares against "last" values so the final toggle of a
  // phase is recognised on the same edge that performs it.
  localparam logic [15:0] START_LAST = 16'(STARTUP_TOGGLES - 1);
  localparam logic [15:0] WIN_LAST   = 16'(WIN_TOGGLES - 1);

  state_t            state_q, state_d;
  logic [24:0]       cnt_q, cnt_d;
  logic [15:0]       tog_q, tog_d;
  logic [N_TASK-1:0] seen_q, seen_d;
  logic              wdi_q, wdi_d;
  logic              fault_q, fault_d;
  logic [N_TASK-1:0] miss_q, miss_d;
  logic [15:0]       kick_q, kick_d;

  logic              terminal;
  logic [24:0]       cnt_next;
  logic [15:0]       kick_inc;
  logic [N_TASK-1:0] hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tog_d    = tog_q;
    seen_d   = seen_q;
    wdi_d    = wdi_q;
    fault_d  = fault_q;
    miss_d   = miss_q;
    kick_d   = kick_q;

    terminal = (cnt_q == HALF_PERIOD);
    cnt_next = terminal ? 25'd0 : cnt_q + 25'd1;
    kick_inc = (kick_q == 16'hFFFF) ? kick_q : kick_q + 16'd1;
    // A heartbeat on the window-end clock itself still counts for that window.
    hit      = seen_q | i_task_alive;

    if (!i_dog_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = STARTUP;
          cnt_d   = '0;
          tog_d   = '0;
          seen_d  = '0;
          wdi_d   = 1'b0;
          fault_d = 1'b0;
          miss_d  = '0;
          kick_d  = '0;
        end
        STARTUP: begin
          cnt_d = cnt_next;
          if (terminal) begin
            wdi_d  = ~wdi_q;
            kick_d = kick_inc;
            if (tog_q == START_LAST) begin
              state_d = RUN;
              tog_d   = '0;
              seen_d  = '0;
            end else begin
              tog_d = tog_q + 16'd1;
            end
          end
        end
        RUN: begin
          if (i_force_starve) begin
            // Overrides anything else this clock, including a passing window end.
            state_d = STARVE;
            fault_d = 1'b1;
            miss_d  = '0;
          end else begin
            cnt_d  = cnt_next;
            seen_d = hit;
            if (terminal) begin
              if (tog_q == WIN_LAST) begin
                if ((hit & i_task_mask) == i_task_mask) begin
                  wdi_d  = ~wdi_q;
                  kick_d = kick_inc;
                  tog_d  = '0;
                  seen_d = '0;
                end else begin
                  state_d = STARVE;
                  fault_d = 1'b1;
                  miss_d  = i_task_mask & ~hit;
                end
              end else begin
                wdi_d  = ~wdi_q;
                kick_d = kick_inc;
                tog_d  = tog_q + 16'd1;
              end
            end
          end
        end
        default: begin
          // STARVE: everything frozen until the enable drops.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      seen_q  <= '0;
      wdi_q   <= 1'b0;
      fault_q <= 1'b0;
      miss_q  <= '0;
      kick_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      seen_q  <= seen_d;
      wdi_q   <= wdi_d;
      fault_q <= fault_d;
      miss_q  <= miss_d;
      kick_q  <= kick_d;
    end
  end

  // Only combinational output: the pin idles high whenever supervision is off.
  assign o_wdi        = (state_q == IDLE) | wdi_q;
  assign o_state      = state_q;
  assign o_fault      = fault_q;
  assign o_miss_tasks = miss_q;
  assign o_kick_cnt   = kick_q;

endmodule

// File: tb/tb_wdg_kick_sched.sv
// tb/tb_wdg_kick_sched.sv - directed self-checking bench for wdg_kick_sched

module tb_wdg_kick_sched;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mask;
  logic [1:0]  alive;
  logic        force_starve;
  logic        wdi;
  logic [1:0]  state;
  logic        fault;
  logic [1:0]  miss;
  logic [15:0] kick;

  int pass_cnt;
  int total_cnt;

  wdg_kick_sched #(
    .HALF_PERIOD    (25'd3),
    .N_TASK         (2),
    .WIN_TOGGLES    (4),
    .STARTUP_TOGGLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_dog_en      (en),
    .i_task_mask   (mask),
    .i_task_alive  (alive),
    .i_force_starve(force_starve),
    .o_wdi         (wdi),
    .o_state       (state),
    .o_fault       (fault),
    .o_miss_tasks  (miss),
    .o_kick_cnt    (kick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leave whatever state we are in, enable, and run to the first RUN clock.
  // On return: RUN, cnt=0, o_wdi=0, o_kick_cnt=2.
  task automatic start_run();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(9);
  endtask

  // One 16-clock window: first_alive on clock 1, end_alive on clock 16.
  task automatic run_window(input logic [1:0] first_alive, input logic [1:0] end_alive);
    for (int s = 1; s <= 16; s++) begin
      alive = (s == 1) ? first_alive : ((s == 16) ? end_alive : 2'b00);
      step(1);
    end
    alive = 2'b00;
  endtask

  task automatic test_reset_startup();
    rst_n = 1'b0;
    en    = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    total_cnt++; if (wdi !== 1'b1) $display("FAIL reset_wdi: got %0b want 1", wdi); else pass_cnt++;
    total_cnt++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else pass_cnt++;
    total_cnt++; if (kick !== 16'd0) $display("FAIL reset_kick: got %0d want 0", kick); else pass_cnt++;
    total_cnt++; if (fault !== 1'b0) $display("FAIL reset_fault: got %0b want 0", fault); else pass_cnt++;
    en = 1'b1;
    step(1);
    total_cnt++; if (state !== 2'd1) $display("FAIL startup_state: got %0d want 1", state); else pass_cnt++;
    total_cnt++; if (wdi !== 1'b0) $display("FAIL startup_wdi_low: got %0b want 0", wdi); else pass_cnt++;
    step(3);
    total_cnt++; if (wdi !== 1'b0) $display("FAIL startup_before_rise: got %0b want 0", wdi); else pass_cnt++;
    step(1);
    total_cnt++; if (wdi !== 1'b1) $display("FAIL startup_first_rise: got %0b want 1", wdi); else pass_cnt++;
    total_cnt++; if (kick !== 16'd1) $display("FAIL startup_kick1: got %0d want 1", kick); else pass_cnt++;
    total_cnt++; if (state !== 2'd1) $display("FAIL startup_still: got %0d want 1", state); else pass_cnt++;
    step(4);
    total_cnt++; if (state !== 2'd2) $display("FAIL run_entry_state: got %0d want 2", state); else pass_cnt++;
    total_cnt++; if (wdi !== 1'b0) $display("FAIL run_entry_wdi: got %0b want 0", wdi); else pass_cnt++;
  endtask

  task automatic test_run_pass();
    logic exp_wdi;
    int   errs;
    exp_wdi = 1'b0;
    mask    = 2'b11;
    for (int w = 0; w < 4; w++) begin
      errs = 0;
      for (int s = 1; s <= 16; s++) begin
        alive = (s == 1) ? 2'b11 : 2'b00;
        step(1);
        if (s % 4 == 0) exp_wdi = ~exp_wdi;
        if (wdi !== exp_wdi) errs++;
      end
      alive = 2'b00;
      total_cnt++; if (errs != 0) $display("FAIL pass_wave w%0d: %0d bad samples want 0", w, errs); else pass_cnt++;
      total_cnt++; if (state !== 2'd2) $display("FAIL pass_state w%0d: got %0d want 2", w, state); else pass_cnt++;
    end
    total_cnt++; if (fault !== 1'b0) $display("FAIL pass_fault: got %0b want 0", fault); else pass_cnt++;
    total_cnt++; if (kick !== 16'd18) $display("FAIL pass_kick: got %0d want 18", kick); else pass_cnt++;
  endtask

  task automatic test_miss();
    run_window(2'b01, 2'b00);
    total_cnt++; if (state !== 2'd3) $display("FAIL miss_state: got %0d want 3", state); else pass_cnt++;
    total_cnt++; if (miss !== 2'b10) $display("FAIL miss_tasks: got %b want 10", miss); else pass_cnt++;
    total_cnt++; if (fault !== 1'b1) $display("FAIL miss_fault: got %0b want 1", fault); else pass_cnt++;
    total_cnt++; if (kick !== 16'd21) $display("FAIL miss_kick: got %0d want 21", kick); else pass_cnt++;
    total_cnt++; if (wdi !== 1'b1) $display("FAIL miss_wdi: got %0b want 1", wdi); else pass_cnt++;
    step(100);
    total_cnt++; if (wdi !== 1'b1) $display("FAIL starve_wdi_frozen: got %0b want 1", wdi); else pass_cnt++;
    total_cnt++; if (kick !== 16'd21) $display("FAIL starve_kick_frozen: got %0d want 21", kick); else pass_cnt++;
    total_cnt++; if (state !== 2'd3) $display("FAIL starve_state_held: got %0d want 3", state); else pass_cnt++;
  endtask

  task automatic test_window_edge();
    start_run();
    total_cnt++; if (fault !== 1'b0) $display("FAIL edge_fault_cleared: got %0b want 0", fault); else pass_cnt++;
    total_cnt++; if (miss !== 2'b00) $display("FAIL edge_miss_cleared: got %b want 00", miss); else pass_cnt++;
    run_window(2'b01, 2'b10);
    total_cnt++; if (state !== 2'd2) $display("FAIL edge_same_clk_pass: got %0d want 2", state); else pass_cnt++;
    total_cnt++; if (kick !== 16'd6) $display("FAIL edge_kick_w1: got %0d want 6", kick); else pass_cnt++;
    run_window(2'b11, 2'b00);
    total_cnt++; if (kick !== 16'd10) $display("FAIL edge_kick_w2: got %0d want 10", kick); else pass_cnt++;
    run_window(2'b01, 2'b00);
    total_cnt++; if (state !== 2'd3) $display("FAIL edge_no_carry_state: got %0d want 3", state); else pass_cnt++;
    total_cnt++; if (miss !== 2'b10) $display("FAIL edge_no_carry_miss: got %b want 10", miss); else pass_cnt++;
    total_cnt++; if (kick !== 16'd13) $display("FAIL edge_no_carry_kick: got %0d want 13", kick); else pass_cnt++;
  endtask

  task automatic test_force_starve();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    force_starve = 1'b1;
    step(1);
    force_starve = 1'b0;
    total_cnt++; if (state !== 2'd1) $display("FAIL force_ignored_startup: got %0d want 1", state); else pass_cnt++;
    step(7);
    total_cnt++; if (state !== 2'd2) $display("FAIL force_run_entry: got %0d want 2", state); else pass_cnt++;
    for (int s = 1; s <= 16; s++) begin
      alive        = (s == 1) ? 2'b11 : 2'b00;
      force_starve = (s == 16);
      step(1);
    end
    alive        = 2'b00;
    force_starve = 1'b0;
    total_cnt++; if (state !== 2'd3) $display("FAIL force_state: got %0d want 3", state); else pass_cnt++;
    total_cnt++; if (miss !== 2'b00) $display("FAIL force_miss: got %b want 00", miss); else pass_cnt++;
    total_cnt++; if (fault !== 1'b1) $display("FAIL force_fault: got %0b want 1", fault); else pass_cnt++;
    total_cnt++; if (kick !== 16'd5) $display("FAIL force_no_toggle: got %0d want 5", kick); else pass_cnt++;
    en = 1'b0;
    step(1);
    total_cnt++; if (state !== 2'd0) $display("FAIL force_idle_state: got %0d want 0", state); else pass_cnt++;
    total_cnt++; if (wdi !== 1'b1) $display("FAIL force_idle_wdi: got %0b want 1", wdi); else pass_cnt++;
    total_cnt++; if (fault !== 1'b1) $display("FAIL force_fault_sticky: got %0b want 1", fault); else pass_cnt++;
    en = 1'b1;
    step(1);
    total_cnt++; if (fault !== 1'b0) $display("FAIL force_fault_cleared: got %0b want 0", fault); else pass_cnt++;
    total_cnt++; if (state !== 2'd1) $display("FAIL force_restart_state: got %0d want 1", state); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run_and_saturation();
    step(8);
    step(5);
    total_cnt++; if (kick !== 16'd3) $display("FAIL midrun_kick_before: got %0d want 3", kick); else pass_cnt++;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    total_cnt++; if (state !== 2'd0) $display("FAIL midrun_reset_state: got %0d want 0", state); else pass_cnt++;
    total_cnt++; if (wdi !== 1'b1) $display("FAIL midrun_reset_wdi: got %0b want 1", wdi); else pass_cnt++;
    total_cnt++; if (kick !== 16'd0) $display("FAIL midrun_reset_kick: got %0d want 0", kick); else pass_cnt++;
    total_cnt++; if ({fault, miss} !== 3'b000) $display("FAIL midrun_reset_flags: got %b want 000", {fault, miss}); else pass_cnt++;
    mask = 2'b00;
    step(9);
    total_cnt++; if (state !== 2'd2) $display("FAIL sat_run_entry: got %0d want 2", state); else pass_cnt++;
    force dut.kick_q = 16'hFFFE;
    #1;
    release dut.kick_q;
    step(4);
    total_cnt++; if (kick !== 16'hFFFF) $display("FAIL sat_reach: got %h want ffff", kick); else pass_cnt++;
    step(12);
    total_cnt++; if (kick !== 16'hFFFF) $display("FAIL sat_hold: got %h want ffff", kick); else pass_cnt++;
    total_cnt++; if (state !== 2'd2) $display("FAIL mask0_pass: got %0d want 2", state); else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst_n        = 1'b0;
    en           = 1'b0;
    mask         = 2'b11;
    alive        = 2'b00;
    force_starve = 1'b0;
    #1;
    test_reset_startup();
    test_run_pass();
    test_miss();
    test_window_edge();
    test_force_starve();
    test_reset_mid_run_and_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
